// File: rtl/video_scaler_fb.sv
// N-buffered frame store: captures source frames into rotating buffers, shows the newest complete one scaled by SCALE.
// Display latency is 2 cycles from de to color/color_de; there is no backpressure, and late pixels of a full frame are dropped.
module video_scaler_fb #(
  parameter int SRC_W    = 160,
  parameter int SRC_H    = 144,
  parameter int PIX_BITS = 2,
  parameter int COLOR_W  = 16,
  parameter int SCALE    = 3,
  parameter int NUM_BUFS = 3
) (
  input  logic                        pclk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [PIX_BITS-1:0]         in_pixel,
  input  logic                        in_frame_start,
  input  logic                        de,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic                        flip_x,
  input  logic                        flip_y,
  input  logic                        pal_we,
  input  logic [PIX_BITS-1:0]         pal_idx,
  input  logic [COLOR_W-1:0]          pal_data,
  input  logic [COLOR_W-1:0]          border_color,
  output logic [COLOR_W-1:0]          color,
  output logic                        color_de,
  output logic                        frame_drop,
  output logic [$clog2(NUM_BUFS)-1:0] rd_buf_idx
);
  localparam int FRAME = SRC_W * SRC_H;
  localparam int BW    = $clog2(NUM_BUFS);
  localparam int FAW   = $clog2(FRAME + 1);
  localparam int MAW   = $clog2(NUM_BUFS * FRAME);
  localparam int XW    = $clog2(SRC_W + 1);
  localparam int YW    = $clog2(SRC_H + 1);
  localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int NPAL  = 1 << PIX_BITS;
  localparam logic [COLOR_W-1:0] CMAX = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] STEP = CMAX / COLOR_W'(NPAL - 1);

  logic [BW-1:0]       wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, ready_buf_q, ready_buf_d;
  logic [BW-1:0]       wr_step, wr_next;
  logic [FAW-1:0]      wr_addr_q, wr_addr_d, wr_base;
  logic                frame_done, wr_en, frame_drop_q, frame_drop_d;
  logic                vsync_q, de_q, vs_fall, flip_x_q, flip_y_q;
  logic [XW-1:0]       x_src_q, x_src_d, fx;
  logic [YW-1:0]       y_src_q, y_src_d, fy;
  logic [SW-1:0]       x_sub_q, x_sub_d, y_sub_q, y_sub_d;
  logic                in_win, in_win_q, de1_q, color_de_q;
  logic [MAW-1:0]      waddr, raddr;
  logic [PIX_BITS-1:0] pix_q;
  logic [COLOR_W-1:0]  color_q;
  logic [COLOR_W-1:0]  pal_q [NPAL];
  logic [PIX_BITS-1:0] mem [NUM_BUFS*FRAME];

  function automatic logic [BW-1:0] bump(input logic [BW-1:0] b);
    return (b == BW'(NUM_BUFS - 1)) ? '0 : b + BW'(1);
  endfunction

  // Skip against the rd_buf that will hold after this edge, so a coincident vsync cannot collide with wr_buf.
  always_comb begin
    vs_fall      = vsync_q && !vsync;
    rd_buf_d     = vs_fall ? ready_buf_q : rd_buf_q;
    wr_step      = bump(wr_buf_q);
    wr_next      = (wr_step == rd_buf_d) ? bump(wr_step) : wr_step;
    frame_done   = in_frame_start && (wr_addr_q == FAW'(FRAME));
    frame_drop_d = in_frame_start && !frame_done;
    wr_buf_d     = frame_done ? wr_next : wr_buf_q;
    ready_buf_d  = frame_done ? wr_buf_q : ready_buf_q;
    wr_base      = in_frame_start ? '0 : wr_addr_q;
    wr_en        = in_valid && (wr_base != FAW'(FRAME));
    wr_addr_d    = wr_en ? wr_base + FAW'(1) : wr_base;
    waddr        = MAW'(wr_buf_d) * MAW'(FRAME) + MAW'(wr_base);
  end

  always_comb begin
    x_src_d = x_src_q;
    x_sub_d = x_sub_q;
    y_src_d = y_src_q;
    y_sub_d = y_sub_q;
    if (!vsync) begin
      x_src_d = '0;
      x_sub_d = '0;
      y_src_d = '0;
      y_sub_d = '0;
    end else begin
      if (!hsync) begin
        x_src_d = '0;
        x_sub_d = '0;
      end else if (de) begin
        if (x_sub_q == SW'(SCALE - 1)) begin
          x_sub_d = '0;
          if (x_src_q != XW'(SRC_W)) x_src_d = x_src_q + XW'(1);
        end else begin
          x_sub_d = x_sub_q + SW'(1);
        end
      end
      if (de_q && !de) begin
        if (y_sub_q == SW'(SCALE - 1)) begin
          y_sub_d = '0;
          if (y_src_q != YW'(SRC_H)) y_src_d = y_src_q + YW'(1);
        end else begin
          y_sub_d = y_sub_q + SW'(1);
        end
      end
    end
    in_win = (x_src_q < XW'(SRC_W)) && (y_src_q < YW'(SRC_H));
    fx     = flip_x_q ? XW'(SRC_W - 1) - x_src_q : x_src_q;
    fy     = flip_y_q ? YW'(SRC_H - 1) - y_src_q : y_src_q;
    raddr  = in_win ? MAW'(rd_buf_q) * MAW'(FRAME) + MAW'(fy) * MAW'(SRC_W) + MAW'(fx) : '0;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_buf_q     <= '0;
      rd_buf_q     <= BW'(NUM_BUFS - 1);
      ready_buf_q  <= BW'(NUM_BUFS - 1);
      wr_addr_q    <= '0;
      frame_drop_q <= 1'b0;
      vsync_q      <= 1'b1;
      de_q         <= 1'b0;
      flip_x_q     <= 1'b0;
      flip_y_q     <= 1'b0;
      x_src_q      <= '0;
      x_sub_q      <= '0;
      y_src_q      <= '0;
      y_sub_q      <= '0;
      in_win_q     <= 1'b0;
      de1_q        <= 1'b0;
      color_de_q   <= 1'b0;
      color_q      <= '0;
      for (int i = 0; i < NPAL; i++) pal_q[i] <= CMAX - COLOR_W'(i) * STEP;
    end else begin
      wr_buf_q     <= wr_buf_d;
      rd_buf_q     <= rd_buf_d;
      ready_buf_q  <= ready_buf_d;
      wr_addr_q    <= wr_addr_d;
      frame_drop_q <= frame_drop_d;
      vsync_q      <= vsync;
      de_q         <= de;
      if (vs_fall) begin
        flip_x_q <= flip_x;
        flip_y_q <= flip_y;
      end
      x_src_q    <= x_src_d;
      x_sub_q    <= x_sub_d;
      y_src_q    <= y_src_d;
      y_sub_q    <= y_sub_d;
      in_win_q   <= in_win;
      de1_q      <= de;
      color_de_q <= de1_q;
      color_q    <= de1_q ? (in_win_q ? pal_q[pix_q] : border_color) : '0;
      if (pal_we) pal_q[pal_idx] <= pal_data;
    end
  end

  always_ff @(posedge pclk) begin
    if (wr_en) mem[waddr] <= in_pixel;
    pix_q <= mem[raddr];
  end

  assign color      = color_q;
  assign color_de   = color_de_q;
  assign frame_drop = frame_drop_q;
  assign rd_buf_idx = rd_buf_q;
endmodule

// File: doc/video_scaler_fb.md
Name: video_scaler_fb

Overview:
Single-clock, parametrised N-buffered frame store with integer upscaling, programmable palette and mirroring. It sits between the GB LCD capture path and the display timing generator. The block captures source pixels into rotating buffers and presents the newest complete frame on each display frame. Output pixels are scaled by SCALE in both axes; pixels outside the scaled image area show a programmable border colour.

Parameters:
SRC_W, 160, source pixels per line
SRC_H, 144, source lines per frame
PIX_BITS, 2, source pixel width (palette index)
COLOR_W, 16, output colour width
SCALE, 3, integer upscale factor (1..4)
NUM_BUFS, 3, frame buffers (3..4)

Ports:
pclk  in  1  clock, shared by capture and display
rst_n  in  1  async active-low reset
in_valid  in  1  source pixel strobe
in_pixel  in  PIX_BITS  source pixel
in_frame_start  in  1  one-cycle pulse, start of source frame
de  in  1  display data enable
hsync  in  1  display hsync, active low
vsync  in  1  display vsync, active low
flip_x  in  1  mirror horizontally
flip_y  in  1  mirror vertically
pal_we  in  1  palette write strobe
pal_idx  in  PIX_BITS  palette entry to write
pal_data  in  COLOR_W  palette write data
border_color  in  COLOR_W  colour used outside the image
color  out  COLOR_W  output pixel
color_de  out  1  de delayed to align with color
frame_drop  out  1  one-cycle pulse: incomplete source frame discarded
rd_buf_idx  out  clog2(NUM_BUFS)  buffer currently displayed

Behaviour:
- Reset, async on rst_n low:
  - wr_buf=0, rd_buf=NUM_BUFS-1, ready_buf=NUM_BUFS-1, wr_addr=0.
  - Display counters are 0.
  - color=0, color_de=0, frame_drop=0.
  - Palette entry i = (2^COLOR_W-1) - i*((2^COLOR_W-1)/(2^PIX_BITS-1)), i.e. index 0 white, max index black.
  - Memory contents are undefined.
- Capture:
  - in_valid with wr_addr<SRC_W*SRC_H: write mem[wr_buf][wr_addr], then increment wr_addr.
  - At wr_addr==SRC_W*SRC_H, further pixels are dropped silently.
- in_frame_start with a complete frame (wr_addr==SRC_W*SRC_H):
  - ready_buf<=wr_buf.
  - wr_buf<=(wr_buf+1)%NUM_BUFS; if that equals rd_buf, take the next index after it.
  - wr_addr<=0.
- in_frame_start with an incomplete frame, including 0 pixels:
  - frame_drop=1 for one cycle.
  - wr_buf is unchanged; wr_addr<=0.
- in_frame_start and in_valid in the same cycle: the frame boundary is processed first, and the pixel is written at address 0 of the resulting wr_buf.
- Invariant: wr_buf never equals rd_buf.
- Display frame start (vsync low):
  - On the 1->0 transition of registered vsync: rd_buf<=ready_buf; flip_x/flip_y are latched for the frame.
  - While vsync is low: y_src, y_sub, x_src, x_sub are held at 0.
- hsync low: x_src and x_sub are held at 0.
- de high, per cycle:
  - x_sub increments; at SCALE-1 it wraps to 0 and x_src increments.
  - x_src saturates at SRC_W.
- de falling edge:
  - y_sub increments; at SCALE-1 it wraps to 0 and y_src increments.
  - y_src saturates at SRC_H.
- Read address:
  - Column term: fx = flip_x ? SRC_W-1-x_src : x_src. Row term: fy = flip_y ? SRC_H-1-y_src : y_src.
  - addr = fy*SRC_W + fx, in rd_buf.
  - Memory read is synchronous (1 cycle).
- Pipeline, stage 1: memory read plus an in_window flag (x_src<SRC_W && y_src<SRC_H).
- Pipeline, stage 2: color <= in_window ? palette[pix] : border_color.
- Latency: color and color_de are exactly 2 cycles after de. color=0 when the delayed de is 0.
- Palette writes:
  - pal_we writes palette[pal_idx] at the clock edge.
  - A colour lookup of the same entry in the same cycle returns the old value.
- rd_buf_idx = rd_buf (registered).

Test Plan:
- Reset -> color=0, color_de=0, frame_drop=0, rd_buf_idx=NUM_BUFS-1; palette reads FFFF/AAAA/5555/0000 (defaults).
- Capture and scaled display:
  - Stimulus: in_frame_start, then 23040 pixels with value (addr%4); in_frame_start; vsync pulse; de for 480 cycles.
  - Response: rd_buf_idx=0; color from cycle 2 is FFFF×3, AAAA×3, 5555×3, 0000×3 ...; each source line repeats on 3 consecutive display lines.
- Short frame: 100 pixels, then in_frame_start -> frame_drop pulses 1 cycle; next vsync leaves rd_buf_idx unchanged.
- Rotation: write 4 complete frames with no vsync -> wr_buf cycles 0,1,0,1 (buffer 2 = rd_buf is skipped); next vsync gives rd_buf_idx=1.
- Mirroring: flip_x=1, flip_y=1 latched at vsync -> first output pixel equals source pixel (143,159); flip change mid-frame has no effect until the next vsync.
- Border, palette and reset:
  - de held 600 cycles -> display columns 480..599 output border_color=1234.
  - pal_we idx=1 data=F800 -> index-1 pixels show F800 from the next lookup.
  - rst_n low mid-line -> outputs return to reset values immediately.
